// File: rtl/pixel_stream_framer.sv
// Source-side framer: pulls raw pixels from a ready/valid source and emits them
// with column / light-field marker strobes, inserting a programmable gap between columns.
module pixel_stream_framer #(
    parameter int PIXEL_W = 24,
    parameter int ROWS    = 64,
    parameter int COLS    = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [7:0]         gap_cycles,
    input  logic [PIXEL_W-1:0] src_data,
    input  logic               src_valid,
    output logic               src_ready,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_valid_out,
    output logic               soc_out,
    output logic               eoc_out,
    output logic               solf_out,
    output logic               eolf_out,
    output logic               busy,
    output logic               done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [7:0]    gap_reg;
    logic [7:0]    gap_cnt;
    logic          xfer;
    logic          row_last;
    logic          col_last;

    // src_ready depends on state only, so there is no combinational path from src_valid.
    assign src_ready = (state == STREAM);
    assign xfer      = src_valid & src_ready;
    assign row_last  = (row_cnt == ROW_LAST);
    assign col_last  = (col_cnt == COL_LAST);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = STREAM;
            end
            STREAM: begin
                if (xfer && row_last) begin
                    if (col_last)            state_next = DONE;
                    else if (gap_reg != 8'd0) state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd1) state_next = STREAM;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
            gap_reg <= 8'd0;
            gap_cnt <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        gap_reg <= gap_cycles;
                        row_cnt <= '0;
                        col_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (row_last) begin
                            row_cnt <= '0;
                            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                            gap_cnt <= gap_reg;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are qualified by xfer, so they can never appear on an invalid cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            soc_out         <= 1'b0;
            eoc_out         <= 1'b0;
            solf_out        <= 1'b0;
            eolf_out        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            pixel_out       <= xfer ? src_data : '0;
            pixel_valid_out <= xfer;
            soc_out         <= xfer && (row_cnt == '0);
            eoc_out         <= xfer && row_last;
            solf_out        <= xfer && (row_cnt == '0) && (col_cnt == '0);
            eolf_out        <= xfer && row_last && col_last;
            busy            <= (state_next != IDLE);
            done            <= (state == DONE);
        end
    end

endmodule

// File: doc/pixel_stream_framer.md
# pixel_stream_framer

Source-side framer that produces the framed pixel stream consumed by the low-pass filter blocks: pixel word, pixel valid, and the four marker strobes soc/eoc (start/end of column) and solf/eolf (start/end of light field). It pulls raw 24-bit pixel words from an upstream ready/valid source, such as a FIFO or frame-buffer reader. It counts them into columns of ROWS pixels and frames of COLS columns, and inserts a programmable idle gap between columns. It is the hardware counterpart of the stream generator that produces the simulation stimulus streams.

## Interface
- PIXEL_W, 24, pixel word width.
- ROWS, 64, valid pixels per column (≥1).
- COLS, 64, columns per light field (≥1).
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to stream one light field.
- gap_cycles  in  8  idle cycles inserted after each non-final column; sampled on accepted start.
- src_data  in  PIXEL_W  upstream pixel word.
- src_valid  in  1  upstream word available.
- src_ready  out  1  framer accepts word this cycle.
- pixel_out  out  PIXEL_W  framed pixel.
- pixel_valid_out  out  1  pixel_out valid.
- soc_out / eoc_out  out  1 each  first / last valid pixel of column.
- solf_out / eolf_out  out  1 each  first / last valid pixel of light field.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the eolf pixel.

## Operation
- States: IDLE, STREAM, GAP, DONE.
- IDLE: start=1 → STREAM. Latch gap_cycles into gap_reg. Clear row_cnt and col_cnt. busy=1 from the next cycle.
- start is ignored in every state except IDLE.
- STREAM: src_ready=1 combinationally. A transfer occurs when src_valid & src_ready.
- Each transfer registers: pixel_out=src_data and pixel_valid_out=1.
  - soc_out=(row_cnt==0).
  - eoc_out=(row_cnt==ROWS-1).
  - solf_out=(row_cnt==0 && col_cnt==0).
  - eolf_out=(row_cnt==ROWS-1 && col_cnt==COLS-1).
- No transfer in a cycle: next cycle pixel_valid_out=0, all four strobes 0, pixel_out=0. This is an invalid gap; the downstream tolerates it.
- row_cnt increments per transfer and wraps to 0 at ROWS-1. On wrap, col_cnt increments.
- After the eoc transfer of a non-final column:
  - gap_reg==0: remain in STREAM.
  - otherwise: GAP, loading gap_cnt=gap_reg.
- GAP: src_ready=0. Outputs are invalid/zero. gap_cnt decrements each cycle; at 1 → STREAM. The gap therefore lasts exactly gap_reg cycles.
- After the eolf transfer → DONE. src_ready=0. done=1 for exactly one cycle. Then IDLE with busy=0.
- ROWS=1: soc and eoc are asserted on the same pixel. ROWS=COLS=1: all four strobes are asserted on the single pixel.
- Strobes are never asserted while pixel_valid_out=0.
- Counter widths are $clog2 of ROWS/COLS, minimum 1 bit. No arithmetic exceeds counter width.
- Reset (asynchronous, at any time including mid-frame):
  - State goes to IDLE and all counters clear.
  - Outputs: pixel_out=0, pixel_valid_out=0, all strobes 0, busy=0, done=0, src_ready=0.
  - No partial frame resumes after reset release.

## Timing
- Latency: a src transfer at edge N → pixel and strobes visible after edge N, for one cycle only.
- Every output is a register, except src_ready, which is decoded from state only (no src_valid path).
- Back-to-back transfers give 1 pixel/cycle with no bubbles inside a column.
- Minimum frame duration, with src_valid held high:
  - ROWS·COLS transfer cycles, plus
  - (COLS-1)·gap_reg gap cycles, plus
  - 1 start cycle and 1 DONE cycle.
- done rises 1 cycle after the eolf pixel appears on the output. busy falls with the done→IDLE transition.
- A start asserted during the DONE cycle is ignored. A new frame needs start while in IDLE.

## Test plan
- **Basic frame.** ROWS=4, COLS=3, gap_cycles=0, src_valid=1 constantly, src_data=index 0..11.
  - Expect 12 contiguous valid pixels 0..11.
  - soc on 0,4,8; eoc on 3,7,11; solf on 0 only; eolf on 11 only.
  - done 1 cycle after pixel 11.
- **Gaps.** Same setup with gap_cycles=5.
  - Exactly 5 invalid cycles after pixel 3 and after pixel 7; none after pixel 11.
  - Total 12 valid + 10 gap cycles.
- **Source stalls.** src_valid toggles 1,0,1,0,….
  - Output valid alternates accordingly.
  - Strobes land only on valid cycles, on the same pixel indices as the basic frame.
- **Degenerate sizes.** ROWS=1, COLS=1.
  - Single pixel with soc, eoc, solf and eolf all 1 in the same cycle. done follows.
- **Reset mid-frame.** Assert reset_n=0 after pixel 6.
  - All outputs go 0 immediately (asynchronously) and src_ready=0.
  - After release, a fresh start yields pixel 0 with solf=1 and a complete 12-pixel frame.
- **Start while busy.** Pulse start during STREAM and during DONE.
  - Ignored: frame count and strobe positions are unchanged. Only an IDLE start launches the next frame.
